// File: rtl/ascon_round_engine.sv
// Iterative Ascon permutation: one full round (constant, S-box, linear layer) per clock.
// Also holds the round-constant stage, which is driven by ctr and rounds.
module ascon_round_engine #(
    parameter int W_CTR      = 5,
    parameter int MAX_ROUNDS = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [W_CTR-1:0]   rounds_in,
    input  logic [319:0]       state_in,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [W_CTR-1:0]   ctr,
    output logic [W_CTR-1:0]   rounds,
    output logic [319:0]       state_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t         fsm;
    logic [319:0] perm_state;
    logic [319:0] round_out;
    logic         rounds_ok;
    logic [7:0]   rc_base;
    logic [7:0]   rc_step;
    logic [7:0]   rc;

    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] s0, s1, s2, s3, s4;
    logic [63:0] l0, l1, l2, l3, l4;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    assign rounds_ok = (rounds_in == W_CTR'(6)) || (rounds_in == W_CTR'(8)) ||
                       (rounds_in == W_CTR'(MAX_ROUNDS));

    // Round constant: a per-round-count base, stepping down by 0x0f each round.
    always_comb begin
        rc_base = 8'hF0;
        case (rounds)
            W_CTR'(6): rc_base = 8'h96;
            W_CTR'(8): rc_base = 8'hB4;
            default:   rc_base = 8'hF0;
        endcase
        rc_step = 8'(ctr) - 8'd1;
        rc      = rc_base - rc_step * 8'd15;
    end

    always_comb begin
        x0 = perm_state[319:256];
        x1 = perm_state[255:192];
        x2 = perm_state[191:128] ^ {56'd0, rc};
        x3 = perm_state[127:64];
        x4 = perm_state[63:0];

        // Bit-sliced S-box across all 64 columns.
        a0 = x0 ^ x4;
        a1 = x1;
        a2 = x2 ^ x1;
        a3 = x3;
        a4 = x4 ^ x3;
        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;
        b0 = a0 ^ t1;
        b1 = a1 ^ t2;
        b2 = a2 ^ t3;
        b3 = a3 ^ t4;
        b4 = a4 ^ t0;
        s0 = b0 ^ b4;
        s1 = b1 ^ b0;
        s2 = ~b2;
        s3 = b3 ^ b2;
        s4 = b4;

        l0 = s0 ^ rotr(s0, 19) ^ rotr(s0, 28);
        l1 = s1 ^ rotr(s1, 61) ^ rotr(s1, 39);
        l2 = s2 ^ rotr(s2, 1)  ^ rotr(s2, 6);
        l3 = s3 ^ rotr(s3, 10) ^ rotr(s3, 17);
        l4 = s4 ^ rotr(s4, 7)  ^ rotr(s4, 41);

        round_out = {l0, l1, l2, l3, l4};
    end

    // Control FSM; state_out is captured on entry to DONE, done follows one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm        <= IDLE;
            perm_state <= '0;
            ctr        <= '0;
            rounds     <= '0;
            ready      <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            state_out  <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        perm_state <= state_in;
                        rounds     <= rounds_in;
                        ctr        <= W_CTR'(1);
                        ready      <= 1'b0;
                        if (rounds_ok) begin
                            fsm  <= RUN;
                            busy <= 1'b1;
                        end else begin
                            fsm       <= DONE;
                            state_out <= state_in;
                        end
                    end
                end
                RUN: begin
                    perm_state <= round_out;
                    if (ctr == rounds) begin
                        fsm       <= DONE;
                        busy      <= 1'b0;
                        state_out <= round_out;
                    end else begin
                        ctr <= ctr + W_CTR'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    ready <= 1'b1;
                    fsm   <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule
